// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit.
//   lsu_op_e     : LSU operation codes (loads 0..4, stores 5..7)
//   CMD_*        : memory size commands (word/half/byte)
//   lsu_state_e  : LSU control FSM states
//   op_is_load   : true for LW/LH/LHU/LB/LBU
//   op_cmd       : size command for an op
//   op_misaligned: true when the address low bits violate the access size
//   op_align     : address aligned down to the access size
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_LW  = 3'd0,
        LSU_LH  = 3'd1,
        LSU_LHU = 3'd2,
        LSU_LB  = 3'd3,
        LSU_LBU = 3'd4,
        LSU_SW  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SB  = 3'd7
    } lsu_op_e;

    localparam logic [1:0] CMD_WORD = 2'd0;
    localparam logic [1:0] CMD_HALF = 2'd1;
    localparam logic [1:0] CMD_BYTE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    function automatic logic op_is_load(lsu_op_e op);
        return !(op inside {LSU_SW, LSU_SH, LSU_SB});
    endfunction

    function automatic logic [1:0] op_cmd(lsu_op_e op);
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: return CMD_HALF;
            LSU_LB, LSU_LBU, LSU_SB: return CMD_BYTE;
            default:                 return CMD_WORD;
        endcase
    endfunction

    function automatic logic op_misaligned(lsu_op_e op, logic [1:0] lsb);
        case (op_cmd(op))
            CMD_WORD: return lsb != 2'b00;
            CMD_HALF: return lsb[0];
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] op_align(lsu_op_e op, logic [31:0] addr);
        case (op_cmd(op))
            CMD_WORD: return {addr[31:2], 2'b00};
            CMD_HALF: return {addr[31:1], 1'b0};
            default:  return addr;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if
// Request/response channel between the MEM pipeline stage and the LSU.
//   req_valid/req_ready : request handshake
//   req_op/addr/wdata   : operation, byte address, right-justified store data
//   resp_valid/ready    : response handshake
//   resp_rdata/error    : extended load data, access-rejected flag
// Modports: master = pipeline side, slave = LSU side.
// -----------------------------------------------------------------------------
interface lsu_if;
    import lsu_pkg::*;

    logic        req_valid;
    logic        req_ready;
    lsu_op_e     req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );

endinterface

// File: rtl/lsu_load_extend.sv
// -----------------------------------------------------------------------------
// lsu_load_extend
// Combinational load-data extension. The memory returns half/byte slices
// right-justified, so only the upper bits need filling.
//   op_i   : load operation
//   raw_i  : raw memory read data
//   data_o : sign/zero-extended result
// -----------------------------------------------------------------------------
module lsu_load_extend
    import lsu_pkg::*;
(
    input  lsu_op_e     op_i,
    input  logic [31:0] raw_i,
    output logic [31:0] data_o
);

    always_comb begin
        case (op_i)
            LSU_LB:  data_o = {{24{raw_i[7]}}, raw_i[7:0]};
            LSU_LBU: data_o = {24'd0, raw_i[7:0]};
            LSU_LH:  data_o = {{16{raw_i[15]}}, raw_i[15:0]};
            LSU_LHU: data_o = {16'd0, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator side of the data-memory port. Accepts one load/store at a time,
// checks legality, drives the memory for one cycle, captures and extends the
// registered read data, and returns a response.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_if (slave)        : request/response channel from the MEM stage
//   mem_r_en_o/mem_w_en_o : memory enables (high only in ST_MEM)
//   mem_address_o         : latched byte address
//   mem_w_data_o          : latched store data (unmodified)
//   mem_read_command_o    : size command for reads
//   mem_write_command_o   : size command for writes
//   mem_r_data_i          : memory read data, valid in ST_WAIT
// Build option: LSU_MISALIGN_TRAP_EN defined -> misaligned accesses are
// rejected with resp_error; undefined -> address is aligned down and the
// access proceeds. Out-of-range rejection is present in both builds.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    lsu_if.slave        req_if,
    output logic        mem_r_en_o,
    output logic        mem_w_en_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_w_data_o,
    output logic [1:0]  mem_read_command_o,
    output logic [1:0]  mem_write_command_o,
    input  logic [31:0] mem_r_data_i
);

    // 33 bits so the byte limit cannot wrap for very large memories.
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    lsu_state_e  state_q, state_d;
    lsu_op_e     op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        req_ready;
    logic        resp_valid;
    logic        r_en;
    logic        w_en;
    logic        out_of_range;
    logic        illegal;
    logic [31:0] ext_data;

    lsu_load_extend u_extend (
        .op_i   (op_q),
        .raw_i  (mem_r_data_i),
        .data_o (ext_data)
    );

    assign out_of_range = {1'b0, req_if.req_addr} >= MEM_BYTES;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        error_d    = error_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        r_en       = 1'b0;
        w_en       = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_if.req_valid) begin
                    op_d    = req_if.req_op;
                    wdata_d = req_if.req_wdata;
                    rdata_d = '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    addr_d  = req_if.req_addr;
                    illegal = out_of_range ||
                              op_misaligned(req_if.req_op, req_if.req_addr[1:0]);
`else
                    // Aligning down never changes the range result because
                    // the limit is word aligned.
                    addr_d  = op_align(req_if.req_op, req_if.req_addr);
                    illegal = out_of_range;
`endif
                    error_d = illegal;
                    state_d = illegal ? ST_RESP : ST_MEM;
                end
            end

            ST_MEM: begin
                if (op_is_load(op_q)) begin
                    r_en    = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    w_en    = 1'b1;
                    state_d = ST_RESP;
                end
            end

            ST_WAIT: begin
                // Memory registered the read at the end of ST_MEM.
                rdata_d = ext_data;
                state_d = ST_RESP;
            end

            ST_RESP: begin
                resp_valid = 1'b1;
                if (req_if.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= LSU_LW;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    assign req_if.req_ready  = req_ready;
    assign req_if.resp_valid = resp_valid;
    assign req_if.resp_rdata = rdata_q;
    assign req_if.resp_error = error_q;

    assign mem_r_en_o          = r_en;
    assign mem_w_en_o          = w_en;
    assign mem_address_o       = addr_q;
    assign mem_w_data_o        = wdata_q;
    assign mem_read_command_o  = op_cmd(op_q);
    assign mem_write_command_o = op_cmd(op_q);

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with hand-computed expectations.
// Honours LSU_MISALIGN_TRAP_EN when choosing misalignment expectations.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] mem_address, mem_w_data, mem_r_data;
    logic [1:0]  mem_read_command, mem_write_command;

    int vectors     = 0;
    int miscompares = 0;
    int ren_cnt     = 0;
    int wen_cnt     = 0;

    typedef struct {
        logic        rdy;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          ren;
        int          wen;
        logic [31:0] en_addr;
        logic [1:0]  en_cmd;
        logic [31:0] en_wdata;
    } txn_t;

    lsu_if bus ();

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .req_if              (bus),
        .mem_r_en_o          (mem_r_en),
        .mem_w_en_o          (mem_w_en),
        .mem_address_o       (mem_address),
        .mem_w_data_o        (mem_w_data),
        .mem_read_command_o  (mem_read_command),
        .mem_write_command_o (mem_write_command),
        .mem_r_data_i        (mem_r_data)
    );

    always #5 clk = ~clk;

    // Count enable cycles mid-cycle, independent of the stimulus tasks.
    always @(negedge clk) begin
        if (mem_r_en) ren_cnt++;
        if (mem_w_en) wen_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request with resp_ready high; lat counts edges from accept
    // (inclusive) until resp_valid is seen.
    task automatic run_txn(input lsu_op_e op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd,
                           output txn_t r);
        int ren0, wen0;
        ren0       = ren_cnt;
        wen0       = wen_cnt;
        r.en_addr  = 'x;
        r.en_cmd   = 'x;
        r.en_wdata = 'x;
        mem_r_data       = rd;
        bus.resp_ready   = 1'b1;
        bus.req_op       = op;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        r.rdy = bus.req_ready;
        tick;
        bus.req_valid = 1'b0;
        r.lat = 1;
        while (!bus.resp_valid && r.lat < 8) begin
            if (mem_r_en) begin
                r.en_addr = mem_address;
                r.en_cmd  = mem_read_command;
            end
            if (mem_w_en) begin
                r.en_addr  = mem_address;
                r.en_cmd   = mem_write_command;
                r.en_wdata = mem_w_data;
            end
            tick;
            r.lat++;
        end
        r.rdata = bus.resp_rdata;
        r.err   = bus.resp_error;
        tick;
        r.ren = ren_cnt - ren0;
        r.wen = wen_cnt - wen0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
        vectors++; if ({bus.resp_valid, bus.resp_error} !== 2'b00) begin miscompares++; $display("FAIL reset_resp got %b exp 00", {bus.resp_valid, bus.resp_error}); end
        vectors++; if (bus.resp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", bus.resp_rdata); end
        vectors++; if ({mem_r_en, mem_w_en} !== 2'b00) begin miscompares++; $display("FAIL reset_enables got %b exp 00", {mem_r_en, mem_w_en}); end
        vectors++; if ({mem_address, mem_w_data, mem_read_command, mem_write_command} !== 68'h0) begin
            miscompares++; $display("FAIL reset_mem_bus got %h/%h/%0d/%0d exp 0", mem_address, mem_w_data, mem_read_command, mem_write_command);
        end
    endtask

    task automatic test_lb;
        txn_t r;
        run_txn(LSU_LB, 32'h3, 32'h0, 32'h0000_0080, r);
        vectors++; if (r.rdy !== 1'b1) begin miscompares++; $display("FAIL lb_ready got %b exp 1", r.rdy); end
        vectors++; if (r.lat !== 3) begin miscompares++; $display("FAIL lb_latency got %0d exp 3", r.lat); end
        vectors++; if (r.rdata !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_rdata got %h exp ffffff80", r.rdata); end
        vectors++; if (r.err !== 1'b0) begin miscompares++; $display("FAIL lb_error got %b exp 0", r.err); end
        vectors++; if (r.ren !== 1 || r.wen !== 0) begin miscompares++; $display("FAIL lb_enables got r%0d w%0d exp r1 w0", r.ren, r.wen); end
        vectors++; if (r.en_cmd !== CMD_BYTE || r.en_addr !== 32'h3) begin miscompares++; $display("FAIL lb_cmd_addr got %0d/%h exp 2/3", r.en_cmd, r.en_addr); end
    endtask

    task automatic test_half;
        txn_t r;
        run_txn(LSU_LHU, 32'h2, 32'h0, 32'h0000_F00D, r);
        vectors++; if (r.rdata !== 32'h0000_F00D) begin miscompares++; $display("FAIL lhu_rdata got %h exp 0000f00d", r.rdata); end
        vectors++; if (r.en_cmd !== CMD_HALF) begin miscompares++; $display("FAIL lhu_cmd got %0d exp 1", r.en_cmd); end
        run_txn(LSU_LH, 32'h2, 32'h0, 32'h0000_F00D, r);
        vectors++; if (r.rdata !== 32'hFFFF_F00D) begin miscompares++; $display("FAIL lh_rdata got %h exp fffff00d", r.rdata); end
        vectors++; if (r.lat !== 3) begin miscompares++; $display("FAIL lh_latency got %0d exp 3", r.lat); end
    endtask

    task automatic test_lbu_lw;
        txn_t r;
        run_txn(LSU_LBU, 32'h1, 32'h0, 32'h0000_00FF, r);
        vectors++; if (r.rdata !== 32'h0000_00FF) begin miscompares++; $display("FAIL lbu_rdata got %h exp 000000ff", r.rdata); end
        // Highest legal word.
        run_txn(LSU_LW, 32'hFFC, 32'h0, 32'h8000_0001, r);
        vectors++; if (r.rdata !== 32'h8000_0001 || r.err !== 1'b0) begin miscompares++; $display("FAIL lw_top_word got %h err %b exp 80000001 err 0", r.rdata, r.err); end
        vectors++; if (r.en_cmd !== CMD_WORD || r.en_addr !== 32'hFFC) begin miscompares++; $display("FAIL lw_top_cmd_addr got %0d/%h exp 0/ffc", r.en_cmd, r.en_addr); end
    endtask

    task automatic test_store;
        txn_t r;
        run_txn(LSU_SW, 32'h10, 32'hDEAD_BEEF, 32'h1111_1111, r);
        vectors++; if (r.lat !== 2) begin miscompares++; $display("FAIL sw_latency got %0d exp 2", r.lat); end
        vectors++; if (r.wen !== 1 || r.ren !== 0) begin miscompares++; $display("FAIL sw_enables got r%0d w%0d exp r0 w1", r.ren, r.wen); end
        vectors++; if (r.en_addr !== 32'h10 || r.en_cmd !== CMD_WORD) begin miscompares++; $display("FAIL sw_addr_cmd got %h/%0d exp 10/0", r.en_addr, r.en_cmd); end
        vectors++; if (r.en_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL sw_wdata got %h exp deadbeef", r.en_wdata); end
        vectors++; if (r.rdata !== 32'h0 || r.err !== 1'b0) begin miscompares++; $display("FAIL sw_resp got %h err %b exp 0 err 0", r.rdata, r.err); end
    endtask

    task automatic test_misaligned;
        txn_t r;
        run_txn(LSU_LW, 32'h6, 32'h0, 32'hCAFE_0000, r);
`ifdef LSU_MISALIGN_TRAP_EN
        vectors++; if (r.lat !== 1 || r.err !== 1'b1) begin miscompares++; $display("FAIL lw_mis_trap got lat %0d err %b exp lat 1 err 1", r.lat, r.err); end
        vectors++; if (r.ren !== 0 || r.wen !== 0) begin miscompares++; $display("FAIL lw_mis_enables got r%0d w%0d exp r0 w0", r.ren, r.wen); end
        vectors++; if (r.rdata !== 32'h0) begin miscompares++; $display("FAIL lw_mis_rdata got %h exp 0", r.rdata); end
`else
        vectors++; if (r.lat !== 3 || r.err !== 1'b0) begin miscompares++; $display("FAIL lw_mis_align got lat %0d err %b exp lat 3 err 0", r.lat, r.err); end
        vectors++; if (r.en_addr !== 32'h4) begin miscompares++; $display("FAIL lw_mis_addr got %h exp 4", r.en_addr); end
        vectors++; if (r.rdata !== 32'hCAFE_0000) begin miscompares++; $display("FAIL lw_mis_rdata got %h exp cafe0000", r.rdata); end
`endif
        run_txn(LSU_SH, 32'h3, 32'h0000_1234, 32'h0, r);
`ifdef LSU_MISALIGN_TRAP_EN
        vectors++; if (r.err !== 1'b1 || r.wen !== 0) begin miscompares++; $display("FAIL sh_mis_trap got err %b w%0d exp err 1 w0", r.err, r.wen); end
`else
        vectors++; if (r.en_addr !== 32'h2 || r.en_cmd !== CMD_HALF || r.wen !== 1) begin
            miscompares++; $display("FAIL sh_mis_align got %h/%0d w%0d exp 2/1 w1", r.en_addr, r.en_cmd, r.wen);
        end
`endif
    endtask

    task automatic test_out_of_range;
        txn_t r;
        // Leave a nonzero result behind so the error path must clear it.
        run_txn(LSU_LW, 32'h8, 32'h0, 32'h5A5A_5A5A, r);
        run_txn(LSU_SB, 32'h1000, 32'h0000_00AA, 32'h0, r);
        vectors++; if (r.lat !== 1 || r.err !== 1'b1) begin miscompares++; $display("FAIL sb_range got lat %0d err %b exp lat 1 err 1", r.lat, r.err); end
        vectors++; if (r.wen !== 0 || r.ren !== 0) begin miscompares++; $display("FAIL sb_range_enables got r%0d w%0d exp r0 w0", r.ren, r.wen); end
        vectors++; if (r.rdata !== 32'h0) begin miscompares++; $display("FAIL sb_range_rdata got %h exp 0", r.rdata); end
        run_txn(LSU_LW, 32'h1000, 32'h0, 32'h0, r);
        vectors++; if (r.err !== 1'b1 || r.ren !== 0) begin miscompares++; $display("FAIL lw_range got err %b r%0d exp err 1 r0", r.err, r.ren); end
    endtask

    task automatic test_backpressure;
        bus.resp_ready = 1'b0;
        mem_r_data     = 32'h1234_5678;
        bus.req_op     = LSU_LW;
        bus.req_addr   = 32'h20;
        bus.req_valid  = 1'b1;
        tick;
        bus.req_valid = 1'b0;
        tick;
        tick;
        mem_r_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus.resp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_%0d got %b exp 1", i, bus.resp_valid); end
            vectors++; if (bus.resp_rdata !== 32'h1234_5678) begin miscompares++; $display("FAIL bp_rdata_%0d got %h exp 12345678", i, bus.resp_rdata); end
            vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready_%0d got %b exp 0", i, bus.req_ready); end
            tick;
        end
        bus.resp_ready = 1'b1;
        tick;
        vectors++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_release got valid %b ready %b exp 0 1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset_in_wait;
        mem_r_data    = 32'h0000_0055;
        bus.req_op    = LSU_LW;
        bus.req_addr  = 32'h40;
        bus.req_valid = 1'b1;
        tick;
        bus.req_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        vectors++; if (bus.req_ready !== 1'b1 || mem_r_en !== 1'b0) begin
            miscompares++; $display("FAIL rst_wait_idle got ready %b r_en %b exp 1 0", bus.req_ready, mem_r_en);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wait_valid_%0d got %b exp 0", i, bus.resp_valid); end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        txn_t r;
        run_txn(LSU_SB, 32'h20, 32'h0000_00AB, 32'h0, r);
        vectors++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_after_resp got valid %b ready %b exp 0 1", bus.resp_valid, bus.req_ready);
        end
        vectors++; if (r.en_cmd !== CMD_BYTE || r.en_wdata !== 32'hAB) begin miscompares++; $display("FAIL b2b_sb got %0d/%h exp 2/ab", r.en_cmd, r.en_wdata); end
        run_txn(LSU_LB, 32'h21, 32'h0, 32'h0000_007F, r);
        vectors++; if (r.rdy !== 1'b1 || r.lat !== 3) begin miscompares++; $display("FAIL b2b_accept got ready %b lat %0d exp 1 3", r.rdy, r.lat); end
        vectors++; if (r.rdata !== 32'h0000_007F) begin miscompares++; $display("FAIL b2b_lb_rdata got %h exp 0000007f", r.rdata); end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = LSU_LW;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b1;
        mem_r_data     = 32'h0;
        rst            = 1'b0;

        test_reset;
        test_lb;
        test_half;
        test_lbu_lw;
        test_store;
        test_misaligned;
        test_out_of_range;
        test_backpressure;
        test_reset_in_wait;
        test_back_to_back;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
